// File: rtl/message_concat_pad_dispatch_if.sv
// Bus between the suffix counter, the key decoder, the dispatcher and the hash-core lanes.
// slave is the dispatcher side; master is the surrounding environment.
interface message_concat_pad_dispatch_if #(
  parameter int MAX_KEY_LENGTH    = 16,
  parameter int MAX_SUFFIX_LENGTH = 8,
  parameter int LANES             = 4,
  parameter int TAG_WIDTH         = 32
);
  localparam int KW = $clog2(1 + MAX_KEY_LENGTH);
  localparam int SW = $clog2(1 + MAX_SUFFIX_LENGTH);
  localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;

  logic                         secret_key_valid;
  logic [KW-1:0]                secret_key_chars;
  logic [8*MAX_KEY_LENGTH-1:0]  secret_key_value;
  logic                         suffix_ready;
  logic                         suffix_valid;
  logic [SW-1:0]                suffix_digits;
  logic [8*MAX_SUFFIX_LENGTH-1:0] suffix_number;
  logic [TAG_WIDTH-1:0]         suffix_tag;
  logic [LANES-1:0]             blk_ready;
  logic [LANES-1:0]             blk_valid;
  logic [512*LANES-1:0]         blk_data;
  logic [TAG_WIDTH*LANES-1:0]   blk_tag;
  logic [PW-1:0]                lane_ptr;
  logic                         overflow_err;
  logic [31:0]                  accepted_count;

  modport slave (
    input  secret_key_valid, secret_key_chars, secret_key_value,
           suffix_valid, suffix_digits, suffix_number, suffix_tag, blk_ready,
    output suffix_ready, blk_valid, blk_data, blk_tag, lane_ptr,
           overflow_err, accepted_count
  );

  modport master (
    output secret_key_valid, secret_key_chars, secret_key_value,
           suffix_valid, suffix_digits, suffix_number, suffix_tag, blk_ready,
    input  suffix_ready, blk_valid, blk_data, blk_tag, lane_ptr,
           overflow_err, accepted_count
  );
endinterface

// File: rtl/message_concat_pad_dispatch.sv
// Joins key + ASCII suffix into one MD5-padded 512-bit block and dispatches
// blocks strictly round-robin to LANES registered valid/ready output stages.
module message_concat_pad_dispatch #(
  parameter int MAX_KEY_LENGTH    = 16,
  parameter int MAX_SUFFIX_LENGTH = 8,
  parameter int LANES             = 4,
  parameter int TAG_WIDTH         = 32
) (
  input  logic clk,
  input  logic reset,
  message_concat_pad_dispatch_if.slave bus
);
  localparam int          KW   = $clog2(1 + MAX_KEY_LENGTH);
  localparam int          SW   = $clog2(1 + MAX_SUFFIX_LENGTH);
  localparam int          PW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned LAST = LANES - 1;

  logic [KW-1:0]        w_k;
  logic [SW-1:0]        w_d;
  logic [6:0]           w_len;
  logic                 w_ovf;
  logic [511:0]         w_blk;
  logic                 w_free;
  logic                 w_ready;
  logic                 w_accept;
  logic                 w_load;

  logic [LANES-1:0]     r_valid;
  logic [511:0]         r_data [LANES];
  logic [TAG_WIDTH-1:0] r_tag  [LANES];
  logic [PW-1:0]        r_ptr;
  logic                 r_ovf;
  logic [31:0]          r_count;

  assign w_k   = (bus.secret_key_chars > KW'(MAX_KEY_LENGTH)) ? KW'(MAX_KEY_LENGTH)
                                                              : bus.secret_key_chars;
  assign w_d   = (bus.suffix_digits > SW'(MAX_SUFFIX_LENGTH)) ? SW'(MAX_SUFFIX_LENGTH)
                                                              : bus.suffix_digits;
  assign w_len = 7'(w_k) + 7'(w_d);
  assign w_ovf = w_len > 7'd55;

  // Inputs are right-aligned: key char k sits at byte K-1-k of the key vector,
  // and suffix byte k (k >= K) at byte L-1-k of the suffix vector.
  always_comb begin
    w_blk = '0;
    for (int unsigned k = 0; k < 56; k++) begin
      if (k < 32'(w_k))
        w_blk[8*k +: 8] = bus.secret_key_value[8*(32'(w_k) - 1 - k) +: 8];
      else if (k < 32'(w_len))
        w_blk[8*k +: 8] = bus.suffix_number[8*(32'(w_len) - 1 - k) +: 8];
      else if (k == 32'(w_len))
        w_blk[8*k +: 8] = 8'h80;
    end
    w_blk[448 +: 64] = {54'd0, w_len, 3'b000};
  end

  assign w_free   = !r_valid[r_ptr] || bus.blk_ready[r_ptr];
  assign w_ready  = !reset && bus.secret_key_valid && w_free;
  assign w_accept = w_ready && bus.suffix_valid;
  assign w_load   = w_accept && !w_ovf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_ptr   <= '0;
      r_ovf   <= 1'b0;
      r_count <= '0;
      for (int unsigned i = 0; i < LANES; i++) begin
        r_data[i] <= '0;
        r_tag[i]  <= '0;
      end
    end else begin
      // Reload wins over drain so a lane can be refilled without a bubble.
      for (int unsigned i = 0; i < LANES; i++) begin
        if (w_load && (32'(r_ptr) == i)) begin
          r_valid[i] <= 1'b1;
          r_data[i]  <= w_blk;
          r_tag[i]   <= bus.suffix_tag;
        end else if (bus.blk_ready[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
      if (w_load && (LANES > 1))
        r_ptr <= (32'(r_ptr) == LAST) ? '0 : r_ptr + PW'(1);
      if (w_accept)
        r_count <= r_count + 32'd1;
      if (w_accept && w_ovf)
        r_ovf <= 1'b1;
    end
  end

  assign bus.suffix_ready   = w_ready;
  assign bus.blk_valid      = r_valid;
  assign bus.lane_ptr       = r_ptr;
  assign bus.overflow_err   = r_ovf;
  assign bus.accepted_count = r_count;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign bus.blk_data[512*g +: 512]            = r_data[g];
    assign bus.blk_tag[TAG_WIDTH*g +: TAG_WIDTH] = r_tag[g];
  end
endmodule
